// File: rtl/lcd_bus_monitor.sv
// lcd_bus_monitor
//   Responder-side model of an HD44780-style character LCD write bus.
//   Synchronizes the bus, captures a transaction on each lcd_e fall, decodes
//   the instruction subset and maintains a 2x16 shadow DDRAM plus the address
//   counter and display flags.
// Ports:
//   clk, rst (async, active-low)
//   lcd_e/lcd_rs/lcd_rw/lcd_data : raw LCD bus inputs
//   rd_addr/rd_data              : registered shadow read port (cell 0-31)
//   ac, disp_on, cursor_on, blink_on, cfg_8bit, cfg_lines : panel state
//   busy                          : clear sweep in progress
//   cmd_valid/cmd_rs/cmd_byte     : one-cycle report of each captured strobe
//   err                           : sticky (read strobe or strobe while busy)
module lcd_bus_monitor #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lcd_e,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic [7:0] lcd_data,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] ac,
  output logic       disp_on,
  output logic       cursor_on,
  output logic       blink_on,
  output logic       cfg_8bit,
  output logic       cfg_lines,
  output logic       busy,
  output logic       cmd_valid,
  output logic       cmd_rs,
  output logic [7:0] cmd_byte,
  output logic       err
);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  // lcd_e carries one extra history flop beyond the synchronizer so the fall
  // is seen as (history=1, last sync stage=0).
  logic [SYNC_STAGES:0]        e_q, e_d;
  logic [SYNC_STAGES-1:0]      rs_q, rs_d, rw_q, rw_d;
  logic [SYNC_STAGES-1:0][7:0] data_q, data_d;

  // Captured transaction, executed one cycle after capture.
  logic       cap_vld_q, cap_vld_d, cap_rs_q, cap_rs_d, cap_rw_q, cap_rw_d;
  logic [7:0] cap_byte_q, cap_byte_d;

  logic [6:0]       ac_q, ac_d;
  logic             inc_q, inc_d;
  logic             disp_q, disp_d, cur_q, cur_d, blink_q, blink_d;
  logic             dl_q, dl_d, n_q, n_d;
  logic             err_q, err_d;
  logic             cmd_valid_q, cmd_valid_d, cmd_rs_q, cmd_rs_d;
  logic [7:0]       cmd_byte_q, cmd_byte_d;
  logic [31:0][7:0] mem_q, mem_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic [4:0]       clr_idx_q, clr_idx_d;
  state_t           state_q, state_d;
  logic             start_clr;
  logic             fall;

  function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
    if (up) begin
      if (a == 7'h27) return 7'h40;
      if (a == 7'h67) return 7'h00;
      return a + 7'd1;
    end
    if (a == 7'h00) return 7'h67;
    if (a == 7'h40) return 7'h27;
    return a - 7'd1;
  endfunction

  assign fall = e_q[SYNC_STAGES] & ~e_q[SYNC_STAGES-1];

  // FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_clr) state_d = S_CLEAR;
      S_CLEAR: if (clr_idx_q == 5'd31) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == S_CLEAR);
  end

  // Datapath next-state
  always_comb begin
    e_d        = {e_q[SYNC_STAGES-1:0], lcd_e};
    rs_d       = {rs_q[SYNC_STAGES-2:0], lcd_rs};
    rw_d       = {rw_q[SYNC_STAGES-2:0], lcd_rw};
    data_d     = {data_q[SYNC_STAGES-2:0], lcd_data};

    cap_vld_d  = fall;
    cap_rs_d   = cap_rs_q;
    cap_rw_d   = cap_rw_q;
    cap_byte_d = cap_byte_q;
    if (fall) begin
      cap_rs_d   = rs_q[SYNC_STAGES-1];
      cap_rw_d   = rw_q[SYNC_STAGES-1];
      cap_byte_d = data_q[SYNC_STAGES-1];
    end

    ac_d        = ac_q;
    inc_d       = inc_q;
    disp_d      = disp_q;
    cur_d       = cur_q;
    blink_d     = blink_q;
    dl_d        = dl_q;
    n_d         = n_q;
    err_d       = err_q;
    mem_d       = mem_q;
    start_clr   = 1'b0;
    cmd_valid_d = cap_vld_q;
    cmd_rs_d    = cmd_rs_q;
    cmd_byte_d  = cmd_byte_q;
    clr_idx_d   = 5'd0;

    if (busy) begin
      mem_d[clr_idx_q] = 8'h20;
      clr_idx_d        = clr_idx_q + 5'd1;
    end

    if (cap_vld_q) begin
      cmd_rs_d   = cap_rs_q;
      cmd_byte_d = cap_byte_q;
      if (cap_rw_q || busy) begin
        err_d = 1'b1;                       // read strobe or dropped write
      end else if (cap_rs_q) begin
        if (ac_q[6:4] == 3'b000)      mem_d[{1'b0, ac_q[3:0]}] = cap_byte_q;
        else if (ac_q[6:4] == 3'b100) mem_d[{1'b1, ac_q[3:0]}] = cap_byte_q;
        ac_d = ac_step(ac_q, inc_q);
      end else begin
        casez (cap_byte_q)
          8'b1???????: ac_d = cap_byte_q[6:0];
          8'b01??????: ;                    // CGRAM address: not modelled
          8'b001?????: begin
            dl_d = cap_byte_q[4];
            n_d  = cap_byte_q[3];
          end
          8'b0001????: if (!cap_byte_q[3]) ac_d = ac_step(ac_q, cap_byte_q[2]);
          8'b00001???: begin
            disp_d  = cap_byte_q[2];
            cur_d   = cap_byte_q[1];
            blink_d = cap_byte_q[0];
          end
          8'b000001??: inc_d = cap_byte_q[1];
          8'b0000001?: ac_d = 7'h00;
          8'b00000001: begin
            ac_d      = 7'h00;
            inc_d     = 1'b1;
            start_clr = 1'b1;
          end
          default: ;
        endcase
      end
    end

    // Reads see the pre-write contents of a cell written this cycle.
    rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_q         <= '0;
      rs_q        <= '0;
      rw_q        <= '0;
      data_q      <= '0;
      cap_vld_q   <= 1'b0;
      cap_rs_q    <= 1'b0;
      cap_rw_q    <= 1'b0;
      cap_byte_q  <= 8'h00;
      ac_q        <= 7'h00;
      inc_q       <= 1'b1;
      disp_q      <= 1'b0;
      cur_q       <= 1'b0;
      blink_q     <= 1'b0;
      dl_q        <= 1'b1;
      n_q         <= 1'b0;
      err_q       <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_rs_q    <= 1'b0;
      cmd_byte_q  <= 8'h00;
      mem_q       <= {32{8'h20}};
      rd_data_q   <= 8'h00;
      clr_idx_q   <= 5'd0;
    end else begin
      e_q         <= e_d;
      rs_q        <= rs_d;
      rw_q        <= rw_d;
      data_q      <= data_d;
      cap_vld_q   <= cap_vld_d;
      cap_rs_q    <= cap_rs_d;
      cap_rw_q    <= cap_rw_d;
      cap_byte_q  <= cap_byte_d;
      ac_q        <= ac_d;
      inc_q       <= inc_d;
      disp_q      <= disp_d;
      cur_q       <= cur_d;
      blink_q     <= blink_d;
      dl_q        <= dl_d;
      n_q         <= n_d;
      err_q       <= err_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_rs_q    <= cmd_rs_d;
      cmd_byte_q  <= cmd_byte_d;
      mem_q       <= mem_d;
      rd_data_q   <= rd_data_d;
      clr_idx_q   <= clr_idx_d;
    end
  end

  assign rd_data   = rd_data_q;
  assign ac        = ac_q;
  assign disp_on   = disp_q;
  assign cursor_on = cur_q;
  assign blink_on  = blink_q;
  assign cfg_8bit  = dl_q;
  assign cfg_lines = n_q;
  assign cmd_valid = cmd_valid_q;
  assign cmd_rs    = cmd_rs_q;
  assign cmd_byte  = cmd_byte_q;
  assign err       = err_q;

endmodule

// File: tb/tb_lcd_bus_monitor.sv
// Directed bench for lcd_bus_monitor (default SYNC_STAGES=2).
module tb_lcd_bus_monitor;

  logic       clk = 1'b0, rst = 1'b0;
  logic       lcd_e = 1'b0, lcd_rs = 1'b0, lcd_rw = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_data, cmd_byte;
  logic [6:0] ac;
  logic       disp_on, cursor_on, blink_on, cfg_8bit, cfg_lines;
  logic       busy, cmd_valid, cmd_rs, err;

  lcd_bus_monitor #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_data(lcd_data), .rd_addr(rd_addr), .rd_data(rd_data), .ac(ac),
    .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
    .cfg_8bit(cfg_8bit), .cfg_lines(cfg_lines), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_rs(cmd_rs), .cmd_byte(cmd_byte), .err(err)
  );

  always #5 clk = ~clk;

  int         compared = 0, mismatched = 0;
  int         lat, pulses, busy_cnt;
  logic       busy_at, got_rs;
  logic [7:0] got_byte, v;

  always @(negedge clk) if (busy) busy_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // One bus strobe: 4 cycles high, then watch 8 negedges for the report pulse.
  task automatic strobe(input logic rs, input logic rw, input logic [7:0] d);
    @(posedge clk); #1;
    lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_e = 1'b1;
    repeat (4) @(posedge clk);
    #1 lcd_e = 1'b0;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (cmd_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = i; busy_at = busy; got_rs = cmd_rs; got_byte = cmd_byte;
        end
      end
    end
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] q);
    @(negedge clk); rd_addr = a;
    @(negedge clk); q = rd_data;
  endtask

  task automatic check_all_blank(input string tag);
    logic [7:0] q;
    for (int i = 0; i < 32; i++) begin
      rd(5'(i), q);
      chk(tag, {24'd0, q}, 32'h20);
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    chk(tag, busy, 0);
  endtask

  initial begin
    pulses = 0; busy_cnt = 0;
    // Reset values while held in reset
    repeat (3) @(negedge clk);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_ac", ac, 0);
    chk("rst_flags", {disp_on, cursor_on, blink_on}, 3'b000);
    chk("rst_cfg", {cfg_8bit, cfg_lines}, 2'b10);
    chk("rst_busy_err", {busy, err}, 2'b00);
    chk("rst_cmd", {cmd_valid, cmd_rs, cmd_byte}, 10'h000);
    rst = 1'b1;

    // Reset mid-activity: write a cell, then reset
    strobe(0, 0, 8'h85);
    strobe(1, 0, 8'h55);
    rd(5'd5, v); chk("pre_rst_cell5", v, 8'h55);
    chk("pre_rst_ac", ac, 7'h06);
    @(negedge clk); rst = 1'b0;
    #1 chk("async_rst_ac", ac, 0);
    @(negedge clk); rst = 1'b1;
    check_all_blank("rst_cells");

    // Init sequence
    pulses = 0;
    strobe(0, 0, 8'h3C);
    chk("latency", lat, 5);
    chk("cmd_3c", {got_rs, got_byte}, 9'h03C);
    strobe(0, 0, 8'h0C);
    strobe(0, 0, 8'h06);
    chk("init_pulses", pulses, 3);
    chk("init_cfg", {cfg_8bit, cfg_lines}, 2'b11);
    chk("init_disp", {disp_on, cursor_on, blink_on}, 3'b100);

    // Line-1 and line-2 writes
    strobe(0, 0, 8'h80);
    strobe(1, 0, 8'h31);
    chk("cmd_data", {got_rs, got_byte}, 9'h131);
    strobe(1, 0, 8'h2B);
    strobe(1, 0, 8'h32);
    rd(5'd0, v); chk("cell0", v, 8'h31);
    rd(5'd1, v); chk("cell1", v, 8'h2B);
    rd(5'd2, v); chk("cell2", v, 8'h32);
    chk("ac_3", ac, 7'h03);
    strobe(0, 0, 8'hC0);
    strobe(1, 0, 8'h3D);
    rd(5'd16, v); chk("cell16", v, 8'h3D);
    chk("ac_41", ac, 7'h41);

    // Unmapped write and wraps
    strobe(0, 0, 8'hA7);
    strobe(1, 0, 8'h41);
    chk("ac_wrap_27_40", ac, 7'h40);
    rd(5'd7, v);  chk("cell7_untouched", v, 8'h20);
    rd(5'd23, v); chk("cell23_untouched", v, 8'h20);
    strobe(0, 0, 8'h04);
    strobe(1, 0, 8'h42);
    rd(5'd16, v); chk("cell16_dec", v, 8'h42);
    chk("ac_wrap_40_27", ac, 7'h27);
    strobe(0, 0, 8'hE7);
    strobe(0, 0, 8'h14);
    chk("cur_right_67_00", ac, 7'h00);
    strobe(0, 0, 8'h10);
    chk("cur_left_00_67", ac, 7'h67);
    strobe(0, 0, 8'h18);
    chk("disp_shift_ignored", ac, 7'h67);
    strobe(0, 0, 8'hCF);
    strobe(1, 0, 8'h5A);
    rd(5'd31, v); chk("cell31", v, 8'h5A);
    chk("ac_4e", ac, 7'h4E);
    strobe(0, 0, 8'h02);
    chk("home_ac", ac, 0);
    strobe(0, 0, 8'h45);
    chk("cgram_ignored", ac, 0);
    strobe(0, 0, 8'h0F);
    chk("disp_0f", {disp_on, cursor_on, blink_on}, 3'b111);
    strobe(0, 0, 8'h20);
    chk("cfg_20", {cfg_8bit, cfg_lines}, 2'b00);
    chk("err_clean", err, 0);

    // Clear sweep
    strobe(0, 0, 8'h07);           // back to increment later via clear; leave ac 0
    strobe(0, 0, 8'h85);
    busy_cnt = 0;
    strobe(0, 0, 8'h01);
    chk("busy_with_pulse", busy_at, 1);
    wait_idle("clr_done");
    chk("busy_cycles", busy_cnt, 32);
    chk("clr_ac", ac, 0);
    check_all_blank("clr_cells");
    chk("clr_err", err, 0);

    // Write during busy is dropped
    strobe(0, 0, 8'h01);
    strobe(1, 0, 8'h77);
    chk("drop_busy_at", busy_at, 1);
    chk("drop_cmd", {got_rs, got_byte}, 9'h177);
    chk("drop_err", err, 1);
    wait_idle("drop_done");
    rd(5'd0, v); chk("drop_cell0", v, 8'h20);
    chk("drop_ac", ac, 0);

    // Reset mid-sweep
    strobe(0, 0, 8'hCF);
    strobe(1, 0, 8'h99);
    rd(5'd31, v); chk("pre_sweep_cell31", v, 8'h99);
    strobe(0, 0, 8'h01);
    repeat (2) @(negedge clk);
    chk("mid_sweep_busy", busy, 1);
    rst = 1'b0;
    #1 chk("rst_abort_busy", busy, 0);
    chk("rst_abort_err", err, 0);
    @(negedge clk); rst = 1'b1;
    rd(5'd31, v); chk("rst_abort_cell31", v, 8'h20);

    // Read strobe
    strobe(0, 0, 8'h80);
    strobe(1, 0, 8'h11);
    strobe(1, 1, 8'h22);
    chk("rw_pulse", lat != 0, 1);
    chk("rw_cmd", {got_rs, got_byte}, 9'h122);
    chk("rw_err", err, 1);
    chk("rw_ac", ac, 7'h01);
    rd(5'd0, v); chk("rw_cell0", v, 8'h11);
    rd(5'd1, v); chk("rw_cell1", v, 8'h20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lcd_bus_monitor.md
# lcd_bus_monitor

Responder-side model of the character-LCD write bus driven by the calculator's LCD sequencer. It samples `lcd_e`, `lcd_rs`, `lcd_rw` and `lcd_data`, latches each transaction on the falling edge of `lcd_e`, and decodes the HD44780 instruction subset. It maintains a 2x16 shadow DDRAM, the address counter and the display flags. The shadow contents are exposed on a read port so that a second display, the on-board debug logic or the testbench can check what the panel is showing.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on all bus inputs; legal range 2–3.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-low.
- `lcd_e` in 1: LCD enable strobe; a transaction completes on its falling edge.
- `lcd_rs` in 1: 0 selects an instruction, 1 selects a data write.
- `lcd_rw` in 1: 0 is a write, 1 is a read.
- `lcd_data` in 8: bus byte.
- `rd_addr` in 5: shadow cell index. Cells 0–15 are line 1 (DDRAM 0x00–0x0F); cells 16–31 are line 2 (DDRAM 0x40–0x4F).
- `rd_data` out 8: registered shadow byte for `rd_addr`.
- `ac` out 7: DDRAM address counter.
- `disp_on`, `cursor_on`, `blink_on` out 1 each: display-control flags.
- `cfg_8bit`, `cfg_lines` out 1 each: function-set DL and N bits.
- `busy` out 1: high while a clear sweep is in progress.
- `cmd_valid` out 1: one-cycle pulse per captured transaction.
- `cmd_rs` out 1, `cmd_byte` out 8: the captured transaction, valid while `cmd_valid` is high.
- `err` out 1: sticky error flag; cleared only by reset.

## Operation
- All four bus inputs pass through `SYNC_STAGES` flops. A fall is detected when the last stage of `lcd_e` is 1 and the stage before it is 0. `rs`, `rw` and `data` are taken from the same synchronizer depth in the same cycle.
- Reset values:
  - All 32 cells are 0x20.
  - `ac`=0, increment mode, `disp_on`/`cursor_on`/`blink_on`=0.
  - `cfg_8bit`=1, `cfg_lines`=0.
  - `busy`=0, `cmd_valid`=0, `cmd_rs`=0, `cmd_byte`=0, `err`=0, `rd_data`=0.
- Every detected fall pulses `cmd_valid` with `cmd_rs`/`cmd_byte`, including dropped transactions.
- rw=1 (read strobe): no state change; set `err`.
- rs=0, rw=0: decode on the highest set bit of the byte.
  - 1xxxxxxx: `ac` = d[6:0].
  - 01xxxxxx (CGRAM address): ignored.
  - 001xxxxx: `cfg_8bit`=d4, `cfg_lines`=d3.
  - 0001xxxx: if d3=0, cursor move; d2=1 steps `ac` +1, otherwise −1, using the wrap rules below. Display shift (d3=1) is ignored.
  - 00001xxx: `disp_on`=d2, `cursor_on`=d1, `blink_on`=d0.
  - 000001xx: increment mode = d1; shift bit d0 ignored.
  - 0000001x: `ac`=0.
  - 00000001: `ac`=0, increment mode=1, start the clear sweep.
  - 00000000: no operation.
- rs=1, rw=0 (data write):
  - If `ac` is in 0x00–0x0F or 0x40–0x4F, write the byte to the mapped cell. Otherwise write nothing; not an error.
  - Then step `ac` by ±1 per increment mode.
- `ac` wrap rules:
  - Increment: 0x27→0x40, 0x67→0x00.
  - Decrement: 0x00→0x67, 0x40→0x27.
  - `ac` after a set-address command is taken as given. Stepping from 0x28–0x3F or 0x68–0x7F is plain 7-bit ±1.
- Clear sweep FSM, IDLE→CLEAR→IDLE:
  - CLEAR writes 0x20 to one cell per cycle, index 0 to 31, with `busy`=1.
  - It returns to IDLE after cell 31.
- A transaction captured while `busy`=1 is dropped: no state change, `err` set, `cmd_valid` still pulses.
- Reset asserted mid-sweep aborts the sweep immediately and applies the reset values.

## Timing
- The bus must hold `lcd_e` high and low for at least `SYNC_STAGES`+1 clk cycles each. `rs`/`rw`/`data` must be stable from `lcd_e` rising until after it falls.
- The first clk edge that samples `lcd_e`=0 is edge 0. Register updates and the `cmd_valid` pulse appear after edge `SYNC_STAGES`+1; with the default that is 3 cycles.
- Clear: `busy` rises in the same cycle as `cmd_valid` and stays high for exactly 32 cycles. All cells read 0x20 once `busy` falls.
- `rd_data` has 1-cycle latency from `rd_addr`. Reading a cell in the same cycle it is written returns the old value.

## Test plan
- Reset: drive `rst`=0 mid-activity, then release → all outputs at their reset values; every cell reads 0x20.
- Init sequence 0x3C, 0x0C, 0x06 (rs=0) → three `cmd_valid` pulses; `cfg_8bit`=1, `cfg_lines`=1, `disp_on`=1, `cursor_on`=0, `blink_on`=0, increment mode.
- 0x80, then data 0x31, 0x2B, 0x32 → cells 0/1/2 read 0x31/0x2B/0x32; `ac`=0x03. Then 0xC0 and data 0x3D → cell 16 reads 0x3D; `ac`=0x41.
- 0xA7, then data 0x41 → nothing written; `ac`=0x40. Then 0x04 (decrement mode) and data 0x42 → cell 16 reads 0x42; `ac`=0x27.
- 0x01 → `busy` high for 32 cycles; all cells 0x20, `ac`=0. A data write launched during `busy` is dropped and sets `err`=1. `rst` low during a sweep → `busy`=0 immediately.
- Strobe with rw=1 → `cmd_valid` pulses, `err`=1, all shadow cells and `ac` unchanged.
